// File: rtl/sha256_round_ctrl.sv
// Round sequencer for one SHA-256 block: feeds letters, round index and schedule
// window to an external round core every 6 cycles, then adds the result to H.
module sha256_round_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [15:0][31:0] i_block,
  input  logic [7:0][31:0]  i_hash_in,
  output logic              o_ready,
  output logic [7:0][31:0]  o_hash,
  output logic              o_hash_valid,
  output logic [7:0][31:0]  o_core_letters,
  output logic [5:0]        o_core_counter,
  output logic [3:0][31:0]  o_core_w,
  output logic              o_core_ready,
  input  logic [7:0][31:0]  i_core_letters,
  input  logic              i_core_letters_valid,
  input  logic [31:0]       i_core_w,
  input  logic              i_core_w_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e            state_q;
  logic [5:0]        t_q;
  logic [15:0][31:0] ring_q;
  logic [7:0][31:0]  h_q;
  logic [7:0][31:0]  letters_q;
  logic [7:0][31:0]  hash_q;
  logic              hash_valid_q;
  logic [7:0][31:0]  core_letters_q;
  logic [5:0]        core_counter_q;
  logic [3:0][31:0]  core_w_q;
  logic              core_ready_q;

  logic [5:0]        t_d;
  logic [3:0]        tap0;
  logic [3:0]        tap1;
  logic [3:0]        tap9;
  logic [3:0]        tap14;
  logic [3:0][31:0]  win_d;
  logic [7:0][31:0]  hash_d;

  assign t_d   = t_q + 6'd1;
  assign tap0  = t_d[3:0];
  assign tap1  = t_d[3:0] + 4'd1;
  assign tap9  = t_d[3:0] + 4'd9;
  assign tap14 = t_d[3:0] + 4'd14;

  // W[t-16] lives in slot t mod 16; W[t-15], W[t-7], W[t-2] are +1, +9, +14 mod 16.
  always_comb begin
    win_d = '0;
    win_d[0] = ring_q[tap0];
    if (t_d >= 6'd16) begin
      win_d[1] = ring_q[tap1];
      win_d[2] = ring_q[tap9];
      win_d[3] = ring_q[tap14];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sum
      assign hash_d[gi] = h_q[gi] + letters_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      t_q            <= '0;
      ring_q         <= '0;
      h_q            <= '0;
      letters_q      <= '0;
      hash_q         <= '0;
      hash_valid_q   <= 1'b0;
      core_letters_q <= '0;
      core_counter_q <= '0;
      core_w_q       <= '0;
      core_ready_q   <= 1'b0;
    end else begin
      core_ready_q <= 1'b0;
      hash_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            ring_q         <= i_block;
            h_q            <= i_hash_in;
            letters_q      <= i_hash_in;
            t_q            <= '0;
            core_letters_q <= i_hash_in;
            core_counter_q <= '0;
            core_w_q       <= {96'd0, i_block[0]};
            core_ready_q   <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_core_w_valid) begin
            ring_q[t_q[3:0]] <= i_core_w;
          end
          if (i_core_letters_valid) begin
            letters_q <= i_core_letters;
            if (t_q == 6'd63) begin
              state_q <= S_DONE;
            end else begin
              // Outputs for the next round are registered here so they are stable during ISSUE.
              t_q            <= t_d;
              core_letters_q <= i_core_letters;
              core_counter_q <= t_d;
              core_w_q       <= win_d;
              core_ready_q   <= 1'b1;
              state_q        <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          hash_q       <= hash_d;
          hash_valid_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Held low while in reset so every output reads zero during an abort.
  assign o_ready        = rst_n && (state_q == S_IDLE);
  assign o_hash         = hash_q;
  assign o_hash_valid   = hash_valid_q;
  assign o_core_letters = core_letters_q;
  assign o_core_counter = core_counter_q;
  assign o_core_w       = core_w_q;
  assign o_core_ready   = core_ready_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: stands in for the round core and checks every cycle
// against a whole-block SHA-256 model plus FIPS "abc" literal expectations.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic [15:0][31:0] i_block;
  logic [7:0][31:0]  i_hash_in;
  logic              o_ready;
  logic [7:0][31:0]  o_hash;
  logic              o_hash_valid;
  logic [7:0][31:0]  o_core_letters;
  logic [5:0]        o_core_counter;
  logic [3:0][31:0]  o_core_w;
  logic              o_core_ready;
  logic [7:0][31:0]  i_core_letters;
  logic              i_core_letters_valid;
  logic [31:0]       i_core_w;
  logic              i_core_w_valid;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_round_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (i_start),
    .i_block              (i_block),
    .i_hash_in            (i_hash_in),
    .o_ready              (o_ready),
    .o_hash               (o_hash),
    .o_hash_valid         (o_hash_valid),
    .o_core_letters       (o_core_letters),
    .o_core_counter       (o_core_counter),
    .o_core_w             (o_core_w),
    .o_core_ready         (o_core_ready),
    .i_core_letters       (i_core_letters),
    .i_core_letters_valid (i_core_letters_valid),
    .i_core_w             (i_core_w),
    .i_core_w_valid       (i_core_w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] l, input logic [31:0] k,
                                                 input logic [31:0] w);
    logic [31:0] t1, t2;
    logic [7:0][31:0] n;
    t1 = l[7] + (rotr(l[4], 6) ^ rotr(l[4], 11) ^ rotr(l[4], 25)) + ((l[4] & l[5]) ^ (~l[4] & l[6])) + k + w;
    t2 = (rotr(l[0], 2) ^ rotr(l[0], 13) ^ rotr(l[0], 22)) + ((l[0] & l[1]) ^ (l[0] & l[2]) ^ (l[1] & l[2]));
    n[0] = t1 + t2; n[1] = l[0]; n[2] = l[1]; n[3] = l[2];
    n[4] = l[3] + t1; n[5] = l[4]; n[6] = l[5]; n[7] = l[6];
    return n;
  endfunction

  // Round-core stand-in: W valid 3 cycles and letters 5 cycles after each issue strobe.
  initial begin
    int issue_c;
    logic [31:0] wres;
    logic [7:0][31:0] lres;
    issue_c = -1;
    i_core_letters = '0; i_core_letters_valid = 1'b0; i_core_w = '0; i_core_w_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && o_core_ready) begin
        if (o_core_counter < 6'd16) wres = o_core_w[0];
        else wres = ss1(o_core_w[3]) + o_core_w[2] + ss0(o_core_w[1]) + o_core_w[0];
        lres = sha_round(o_core_letters, K[o_core_counter], wres);
        issue_c = cyc;
      end
      @(posedge clk); #1;
      i_core_w_valid = 1'b0;
      i_core_letters_valid = 1'b0;
      if (!rst_n) begin
        issue_c = -1;
      end else if (issue_c >= 0) begin
        if (cyc == issue_c + 3) begin i_core_w_valid = 1'b1; i_core_w = wres; end
        if (cyc == issue_c + 5) begin i_core_letters_valid = 1'b1; i_core_letters = lres; issue_c = -1; end
      end else if (o_ready && $urandom_range(3) == 0) begin
        // Stray strobes while idle must be ignored.
        i_core_w_valid = 1'b1; i_core_w = $urandom();
        i_core_letters_valid = 1'b1;
        for (int i = 0; i < 8; i++) i_core_letters[i] = $urandom();
      end
    end
  end

  // Whole-block model: per-round inputs and digest of the accepted block.
  logic [31:0]      m_w [64];
  logic [7:0][31:0] m_let [64];
  logic [7:0][31:0] m_digest;

  task automatic model_load(input logic [15:0][31:0] blk, input logic [7:0][31:0] hin);
    logic [7:0][31:0] l;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) m_w[t] = blk[t];
      else m_w[t] = ss1(m_w[t-2]) + m_w[t-7] + ss0(m_w[t-15]) + m_w[t-16];
    end
    l = hin;
    for (int t = 0; t < 64; t++) begin
      m_let[t] = l;
      l = sha_round(l, K[t], m_w[t]);
    end
    for (int i = 0; i < 8; i++) m_digest[i] = hin[i] + l[i];
  endtask

  // Per-cycle compare: start accepted at cycle a -> round t issues at a+1+6t, valid at a+386.
  initial begin
    int m_acc, rel, t;
    bit exp_ready, exp_valid, exp_issue;
    logic [7:0][31:0] m_hash, m_cl;
    logic [5:0] m_cc;
    logic [3:0][31:0] m_cw;
    m_acc = -1; m_hash = '0; m_cl = '0; m_cc = '0; m_cw = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_acc = -1; m_hash = '0; m_cl = '0; m_cc = '0; m_cw = '0;
        chk("reset_hash", o_hash, 256'd0);
        chk("reset_hash_valid", o_hash_valid, 0);
        chk("reset_core_ready", o_core_ready, 0);
        chk("reset_core_counter", o_core_counter, 0);
        chk("reset_core_letters", o_core_letters, 256'd0);
        chk("reset_core_w", o_core_w, 256'd0);
      end else begin
        exp_ready = (m_acc < 0) || (cyc >= m_acc + 386);
        exp_valid = (m_acc >= 0) && (cyc == m_acc + 386);
        if (exp_valid) m_hash = m_digest;
        exp_issue = 1'b0;
        if (m_acc >= 0) begin
          rel = cyc - m_acc - 1;
          if (rel >= 0 && rel <= 378 && (rel % 6) == 0) begin
            t = rel / 6;
            exp_issue = 1'b1;
            m_cc = t[5:0];
            m_cl = m_let[t];
            if (t < 16) m_cw = {96'd0, m_w[t]};
            else m_cw = {m_w[t-2], m_w[t-7], m_w[t-15], m_w[t-16]};
          end
        end
        chk("ready", o_ready, exp_ready);
        chk("hash_valid", o_hash_valid, exp_valid);
        chk("hash", o_hash, m_hash);
        chk("core_ready", o_core_ready, exp_issue);
        chk("core_counter", o_core_counter, m_cc);
        chk("core_letters", o_core_letters, m_cl);
        chk("core_w", o_core_w, m_cw);
        if (exp_ready && i_start) begin
          model_load(i_block, i_hash_in);
          m_acc = cyc;
        end
      end
    end
  end

  logic [15:0][31:0] abc_blk;
  logic [7:0][31:0]  abc_hin, abc_digest;

  task automatic start_run(input logic [15:0][31:0] blk, input logic [7:0][31:0] hin, output int s);
    @(posedge clk); #1;
    i_block = blk; i_hash_in = hin; i_start = 1'b1; s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 16; i++) i_block[i] = $urandom();
    for (int i = 0; i < 8; i++) i_hash_in[i] = $urandom();
  endtask

  task automatic wait_valid(input logic [15:0][31:0] blk, output int vcyc, output int pulses);
    int last;
    logic [3:0][31:0] e5, e16;
    e5 = '0; e5[0] = blk[5];
    e16[0] = blk[0]; e16[1] = blk[1]; e16[2] = blk[9]; e16[3] = blk[14];
    vcyc = -1; pulses = 0; last = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (o_core_ready) begin
        chk("issue_counter", o_core_counter, pulses);
        if (last >= 0) chk("issue_spacing", cyc - last, 6);
        if (o_core_counter == 6'd5) chk("window_t5", o_core_w, e5);
        if (o_core_counter == 6'd16) chk("window_t16", o_core_w, e16);
        last = cyc;
        pulses++;
      end
      if (o_hash_valid) begin vcyc = cyc; break; end
    end
    if (vcyc < 0) begin
      tests++; fails++;
      $display("FAIL hash_valid_timeout: got no pulse in 500 cycles, required one");
    end
  endtask

  initial begin
    int s, v, p, nv;
    int vc [2];
    logic [15:0][31:0] rb;
    logic [7:0][31:0] rh;

    abc_blk = '0; abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
    abc_hin[0] = 32'h6a09e667; abc_hin[1] = 32'hbb67ae85; abc_hin[2] = 32'h3c6ef372; abc_hin[3] = 32'ha54ff53a;
    abc_hin[4] = 32'h510e527f; abc_hin[5] = 32'h9b05688c; abc_hin[6] = 32'h1f83d9ab; abc_hin[7] = 32'h5be0cd19;
    abc_digest[0] = 32'hba7816bf; abc_digest[1] = 32'h8f01cfea; abc_digest[2] = 32'h414140de; abc_digest[3] = 32'h5dae2223;
    abc_digest[4] = 32'hb00361a3; abc_digest[5] = 32'h96177a9c; abc_digest[6] = 32'hb410ff61; abc_digest[7] = 32'hf20015ad;

    rst_n = 1'b1; i_start = 1'b0; i_block = '0; i_hash_in = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", o_ready, 1);

    // FIPS "abc" with a stray start at cycle 100 that must be ignored.
    start_run(abc_blk, abc_hin, s);
    fork
      wait_valid(abc_blk, v, p);
      begin
        while (cyc < s + 100) begin @(posedge clk); #1; end
        for (int i = 0; i < 16; i++) i_block[i] = $urandom();
        i_start = 1'b1;
        chk("busy_ready_c100", o_ready, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
      end
    join
    chk("abc_digest", o_hash, abc_digest);
    chk("abc_latency", v - s, 386);
    chk("abc_issue_count", p, 64);
    $display("[TB] run abc: digest %h latency %0d issues %0d", o_hash, v - s, p);

    // Abort at cycle 200: everything clears and no digest pulse follows.
    start_run(abc_blk, abc_hin, s);
    while (cyc < s + 200) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_hash", o_hash, 256'd0);
    chk("abort_core_letters", o_core_letters, 256'd0);
    chk("abort_core_counter", o_core_counter, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nv = 0;
    repeat (400) begin @(negedge clk); if (o_hash_valid) nv++; end
    chk("abort_no_valid", nv, 0);
    $display("[TB] run abort: reset at +200, valid pulses after %0d", nv);

    start_run(abc_blk, abc_hin, s);
    wait_valid(abc_blk, v, p);
    chk("abc2_digest", o_hash, abc_digest);
    chk("abc2_latency", v - s, 386);
    $display("[TB] run abc after abort: digest %h latency %0d", o_hash, v - s);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) rb[i] = $urandom();
      for (int i = 0; i < 8; i++) rh[i] = $urandom();
      repeat ($urandom_range(4)) @(posedge clk);
      start_run(rb, rh, s);
      wait_valid(rb, v, p);
      chk("rand_digest", o_hash, m_digest);
      chk("rand_latency", v - s, 386);
      chk("rand_issue_count", p, 64);
      $display("[TB] run rand%0d: digest %h latency %0d", r, o_hash, v - s);
    end

    // Back-to-back: start held high, inputs changing every cycle.
    @(posedge clk); #1;
    i_block = abc_blk; i_hash_in = abc_hin; i_start = 1'b1; s = cyc;
    nv = 0; vc[0] = -1; vc[1] = -1;
    for (int k = 0; k < 800 && nv < 2; k++) begin
      @(negedge clk);
      if (o_hash_valid) begin vc[nv] = cyc; nv++; end
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) i_block[i] = $urandom();
      for (int i = 0; i < 8; i++) i_hash_in[i] = $urandom();
      if (cyc >= s + 771) i_start = 1'b0;
    end
    i_start = 1'b0;
    chk("b2b_first_valid", vc[0] - s, 386);
    chk("b2b_second_valid", vc[1] - s, 772);
    $display("[TB] run b2b: valids at +%0d and +%0d", vc[0] - s, vc[1] - s);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  request to hash one 512-bit block; accepted when i_start && o_ready.
REQ-005 i_block[15:0]  input  16x32  message words W[0..15]; index 0 is the first big-endian word.
REQ-006 i_hash_in[7:0]  input  8x32  chaining value; index 0 = a, index 7 = h.
REQ-007 o_ready  output  1  high when the block is in IDLE.
REQ-008 o_hash[7:0]  output  8x32  digest; o_hash[i] = i_hash_in[i] + final letter[i], mod 2^32.
REQ-009 o_hash_valid  output  1  one-cycle pulse when o_hash updates.
REQ-010 o_core_letters[7:0]  output  8x32  working variables a..h driven to the round core.
REQ-011 o_core_counter  output  6  round index t driven to the round core.
REQ-012 o_core_w[3:0]  output  4x32  schedule window driven to the round core.
REQ-013 o_core_ready  output  1  one-cycle round-issue strobe to the round core.
REQ-014 i_core_letters[7:0]  input  8x32  updated letters from the round core.
REQ-015 i_core_letters_valid  input  1  round-core letters valid, 5 cycles after o_core_ready.
REQ-016 i_core_w  input  32  schedule word W[t] from the round core.
REQ-017 i_core_w_valid  input  1  round-core W valid, 3 cycles after o_core_ready.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: on i_start, load i_block into a 16-entry W ring (entry t mod 16), latch i_hash_in into H registers and into the letter registers, clear t, and go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE (exactly one cycle): o_core_ready=1, o_core_counter=t, o_core_letters=letter registers; go to WAIT.
REQ-021 Window for t<16: o_core_w = {W[0]=ring[t], W[1]=0, W[2]=0, W[3]=0}, so the core reproduces W[t].
REQ-022 Window for t>=16: o_core_w[0]=W[t-16], [1]=W[t-15], [2]=W[t-7], [3]=W[t-2], all read from the ring mod 16.
REQ-023 WAIT: when i_core_w_valid is high, write i_core_w into ring[t mod 16]; rewriting t<16 entries with the same value is permitted.
REQ-024 WAIT: when i_core_letters_valid is high, load i_core_letters into the letter registers; if t==63 go to DONE, else increment t and go to ISSUE.
REQ-025 Round period SHALL be 6 cycles: issue at cycle c, letters valid at c+5, next issue at c+6.
REQ-026 DONE (one cycle): register o_hash[i] = H[i] + letter[i] (32-bit wrap, no carry out), assert o_hash_valid in the following cycle, and return to IDLE.
REQ-027 Latency: with start accepted in cycle 0, round t issues in cycle 1+6t and o_hash_valid is high in exactly cycle 386.
REQ-028 o_hash SHALL hold its value until the next DONE; o_ready is high in the same cycle as o_hash_valid.
REQ-029 i_start while not IDLE SHALL be ignored; i_block and i_hash_in are sampled only on acceptance.
REQ-030 Core valid strobes outside WAIT SHALL be ignored; o_core_letters, o_core_counter and o_core_w SHALL hold their values outside ISSUE.

Reset
REQ-031 When rst_n is low, the block SHALL asynchronously set state=IDLE, t=0, all ring/H/letter registers=0, o_hash=0, o_hash_valid=0, o_core_ready=0, o_core_counter=0, o_core_letters=0, o_core_w=0; o_ready=1 after release.
REQ-032 Reset mid-operation SHALL abort the block with no o_hash_valid pulse; the round core is reset by the same net, inverted.

Verification
REQ-033 FIPS "abc": i_hash_in = 6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19; i_block = 61626380, 14x00000000, 00000018 -> o_hash = ba7816bf,8f01cfea,414140de,5dae2223,b00361a3,96177a9c,b410ff61,f20015ad, with o_hash_valid in cycle 386.
REQ-034 Timing: count o_core_ready pulses -> exactly 64, spaced 6 cycles apart, with o_core_counter = 0..63.
REQ-035 Window check at t=16 -> o_core_w = {ring[0], ring[1], ring[9], ring[14]}; at t=5 -> {W[5],0,0,0}.
REQ-036 i_start pulsed in cycle 100 of a run -> ignored; the digest is unchanged and o_ready stays low until cycle 386.
REQ-037 rst_n low in cycle 200 -> all outputs 0 immediately and no o_hash_valid; a fresh "abc" run afterwards yields the correct digest.
REQ-038 Back-to-back runs: i_start held high -> second block accepted in cycle 386, second o_hash_valid in cycle 772.
